// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock monitor.
// Lock FSM encoding and PLL error-code values.
package pll_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    HOLD      = 2'd3
  } lock_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LAG     = 2'b01;
  localparam logic [1:0] ERR_LEAD    = 2'b11;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  // True when the code marks a cycle as erroneous (illegal included).
  function automatic logic is_err(input logic [1:0] code);
    return code != ERR_NONE;
  endfunction

endpackage

// File: rtl/pll_win_counter.sv
// Windowed saturating event counter.
// total includes the current cycle so window-end sees the full count.
module pll_win_counter #(
  parameter int CNT_BITS = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                hit,
  input  logic                window_end,
  output logic [CNT_BITS-1:0] total
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] acc;

  // Running total with this cycle's event folded in, saturating.
  always_comb begin
    total = acc;
    if (hit && (acc != CNT_MAX)) begin
      total = acc + CNT_ONE;
    end
  end

  // Accumulate within a window; restart at window end or soft clear.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc <= '0;
    end else if (window_end) begin
      acc <= '0;
    end else begin
      acc <= total;
    end
  end

endmodule

// File: rtl/pll_lock_detect.sv
// Lock-quality monitor for the SWIPT digital PLL.
// Integrates error and phase-wrap counts per window; hysteretic lock FSM.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int PHASE_BITS     = 32,
  parameter int WINDOW_LEN     = 1024,
  parameter int CNT_BITS       = 11,
  parameter int LOCK_THRESH    = 16,
  parameter int UNLOCK_THRESH  = 64,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swiptAlive,
  input  logic [1:0]            error,
  input  logic [PHASE_BITS-1:0] phase,
  output logic                  locked,
  output logic [1:0]            lock_state,
  output logic                  lock_event,
  output logic                  unlock_event,
  output logic [CNT_BITS-1:0]   err_count,
  output logic [CNT_BITS-1:0]   wrap_count,
  output logic                  illegal_seen
);

  localparam int WIN_BITS  = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam int GOOD_BITS = $clog2(LOCK_WINDOWS + 1);
  localparam int BAD_BITS  = $clog2(UNLOCK_WINDOWS + 1);

  localparam logic [WIN_BITS-1:0]  WIN_LAST = WIN_BITS'(WINDOW_LEN - 1);
  localparam logic [WIN_BITS-1:0]  WIN_ONE  = WIN_BITS'(1);
  localparam logic [CNT_BITS-1:0]  LOCK_TH  = CNT_BITS'(LOCK_THRESH);
  localparam logic [CNT_BITS-1:0]  UNLK_TH  = CNT_BITS'(UNLOCK_THRESH);
  localparam logic [GOOD_BITS-1:0] GOOD_ONE = GOOD_BITS'(1);
  localparam logic [GOOD_BITS-1:0] GOOD_TGT = GOOD_BITS'(LOCK_WINDOWS);
  localparam logic [BAD_BITS-1:0]  BAD_ONE  = BAD_BITS'(1);
  localparam logic [BAD_BITS-1:0]  BAD_TGT  = BAD_BITS'(UNLOCK_WINDOWS);

  logic [WIN_BITS-1:0]  win;
  logic                 window_end;
  logic                 prev_msb;
  logic                 err_hit;
  logic                 wrap_hit;
  logic [CNT_BITS-1:0]  err_total;
  logic [CNT_BITS-1:0]  wrap_total;
  logic [GOOD_BITS-1:0] good_cnt;
  logic [BAD_BITS-1:0]  bad_cnt;
  lock_state_t          state;
  logic                 unused_phase;

  assign unused_phase = ^phase[PHASE_BITS-2:0];

  assign window_end = swiptAlive && (win == WIN_LAST);
  assign err_hit    = swiptAlive && is_err(error);
  assign wrap_hit   = swiptAlive && phase[PHASE_BITS-1] && !prev_msb;
  assign lock_state = state;

  // Free-running window position while the link is alive.
  always_ff @(posedge clk) begin
    if (rst || !swiptAlive) begin
      win <= '0;
    end else if (win == WIN_LAST) begin
      win <= '0;
    end else begin
      win <= win + WIN_ONE;
    end
  end

  // Previous phase MSB for rising-edge (wrap) detection.
  always_ff @(posedge clk) begin
    if (rst || !swiptAlive) begin
      prev_msb <= 1'b0;
    end else begin
      prev_msb <= phase[PHASE_BITS-1];
    end
  end

  // Sticky flag for the illegal error code; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (swiptAlive && (error == ERR_ILLEGAL)) begin
      illegal_seen <= 1'b1;
    end
  end

  pll_win_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_err_cnt (
    .clk       (clk),
    .rst       (rst),
    .enable    (swiptAlive),
    .hit       (err_hit),
    .window_end(window_end),
    .total     (err_total)
  );

  pll_win_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_wrap_cnt (
    .clk       (clk),
    .rst       (rst),
    .enable    (swiptAlive),
    .hit       (wrap_hit),
    .window_end(window_end),
    .total     (wrap_total)
  );

  // Lock FSM plus window result registers, evaluated at window end.
  always_ff @(posedge clk) begin
    lock_event   <= 1'b0;
    unlock_event <= 1'b0;
    if (rst) begin
      state      <= UNLOCKED;
      locked     <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      err_count  <= '0;
      wrap_count <= '0;
    end else if (!swiptAlive) begin
      state    <= UNLOCKED;
      locked   <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      if (locked) begin
        unlock_event <= 1'b1;
      end
    end else if (window_end) begin
      err_count  <= err_total;
      wrap_count <= wrap_total;
      unique case (state)
        UNLOCKED: begin
          if (err_total <= LOCK_TH) begin
            if (LOCK_WINDOWS == 1) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              lock_event <= 1'b1;
              good_cnt   <= '0;
            end else begin
              state    <= ACQUIRING;
              good_cnt <= GOOD_ONE;
            end
          end
        end
        ACQUIRING: begin
          if (err_total <= LOCK_TH) begin
            if (good_cnt + GOOD_ONE == GOOD_TGT) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              lock_event <= 1'b1;
              good_cnt   <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_ONE;
            end
          end else begin
            state    <= UNLOCKED;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (err_total > UNLK_TH) begin
            if (UNLOCK_WINDOWS == 1) begin
              state        <= UNLOCKED;
              locked       <= 1'b0;
              unlock_event <= 1'b1;
              bad_cnt      <= '0;
            end else begin
              state   <= HOLD;
              bad_cnt <= BAD_ONE;
            end
          end
        end
        HOLD: begin
          if (err_total > UNLK_TH) begin
            if (bad_cnt + BAD_ONE == BAD_TGT) begin
              state        <= UNLOCKED;
              locked       <= 1'b0;
              unlock_event <= 1'b1;
              bad_cnt      <= '0;
            end else begin
              bad_cnt <= bad_cnt + BAD_ONE;
            end
          end else begin
            state   <= LOCKED;
            bad_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect.
// Hand-computed window results, FSM states and event pulse tallies.
module tb_pll_lock_detect;

  localparam int PB = 8;
  localparam int WL = 16;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_LAG  = 2'b01;
  localparam logic [1:0] E_LEAD = 2'b11;
  localparam logic [1:0] E_ILL  = 2'b10;

  logic          clk;
  logic          rst;
  logic          swiptAlive;
  logic [1:0]    error;
  logic [PB-1:0] phase;

  logic          locked;
  logic [1:0]    lock_state;
  logic          lock_event;
  logic          unlock_event;
  logic [4:0]    err_count;
  logic [4:0]    wrap_count;
  logic          illegal_seen;

  logic          locked2;
  logic [1:0]    lock_state2;
  logic          lock_event2;
  logic          unlock_event2;
  logic [3:0]    err_count2;
  logic [3:0]    wrap_count2;
  logic          illegal_seen2;

  int passed;
  int total;
  int lock_pulses;
  int unlock_pulses;
  int both_pulses;

  pll_lock_detect #(
    .PHASE_BITS(PB), .WINDOW_LEN(WL), .CNT_BITS(5),
    .LOCK_THRESH(2), .UNLOCK_THRESH(4),
    .LOCK_WINDOWS(3), .UNLOCK_WINDOWS(2)
  ) dut (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive),
    .error(error), .phase(phase),
    .locked(locked), .lock_state(lock_state),
    .lock_event(lock_event), .unlock_event(unlock_event),
    .err_count(err_count), .wrap_count(wrap_count),
    .illegal_seen(illegal_seen)
  );

  pll_lock_detect #(
    .PHASE_BITS(PB), .WINDOW_LEN(WL), .CNT_BITS(4),
    .LOCK_THRESH(2), .UNLOCK_THRESH(4),
    .LOCK_WINDOWS(3), .UNLOCK_WINDOWS(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive),
    .error(error), .phase(phase),
    .locked(locked2), .lock_state(lock_state2),
    .lock_event(lock_event2), .unlock_event(unlock_event2),
    .err_count(err_count2), .wrap_count(wrap_count2),
    .illegal_seen(illegal_seen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle from a negedge; return at the next negedge.
  task automatic cyc(input logic [1:0] e, input logic [PB-1:0] ph);
    error = e;
    phase = ph;
    @(posedge clk);
    @(negedge clk);
    if (lock_event) lock_pulses++;
    if (unlock_event) unlock_pulses++;
    if (lock_event && unlock_event) both_pulses++;
  endtask

  // One full window; errors at positions first..first+n-1.
  task automatic window(input int first, input int n,
                        input logic [1:0] code, input bit wrap);
    logic [1:0]    e;
    logic [PB-1:0] ph;
    for (int p = 0; p < WL; p++) begin
      e  = (p >= first && p < first + n) ? code : E_NONE;
      ph = (wrap && (p % 4) >= 2) ? 8'h80 : 8'h00;
      cyc(e, ph);
    end
  endtask

  initial begin
    passed = 0; total = 0;
    lock_pulses = 0; unlock_pulses = 0; both_pulses = 0;
    rst = 1'b1; swiptAlive = 1'b0; error = E_NONE; phase = '0;
    @(negedge clk);
    cyc(E_NONE, 8'h00);
    cyc(E_NONE, 8'h00);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_state", 32'(lock_state), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_wrap", 32'(wrap_count), 0);
    chk("rst_illegal", 32'(illegal_seen), 0);
    chk("rst_events", 32'(lock_event | unlock_event), 0);

    rst = 1'b0; swiptAlive = 1'b1;
    for (int i = 0; i < WL - 1; i++) cyc(E_NONE, 8'h00);
    chk("t1_pre_end_state", 32'(lock_state), 0);
    cyc(E_NONE, 8'h00);
    chk("t1_w1_state", 32'(lock_state), 1);
    window(0, 0, E_NONE, 0);
    chk("t1_w2_state", 32'(lock_state), 1);
    chk("t1_w2_locked", 32'(locked), 0);
    window(0, 0, E_NONE, 0);
    chk("t1_w3_state", 32'(lock_state), 2);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_lock_event", 32'(lock_event), 1);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_lock_pulses", 32'(lock_pulses), 1);

    window(0, 5, E_LAG, 0);
    chk("t2_hold_state", 32'(lock_state), 3);
    chk("t2_hold_locked", 32'(locked), 1);
    chk("t2_hold_err", 32'(err_count), 5);
    window(0, 5, E_LAG, 0);
    chk("t2_unl_state", 32'(lock_state), 0);
    chk("t2_unl_locked", 32'(locked), 0);
    chk("t2_unl_event", 32'(unlock_event), 1);
    chk("t2_unl_err", 32'(err_count), 5);
    chk("t2_unl_pulses", 32'(unlock_pulses), 1);

    for (int w = 0; w < 3; w++) window(0, 0, E_NONE, 0);
    chk("t3_relock", 32'(lock_state), 2);
    window(0, 5, E_LEAD, 0);
    chk("t3_hold", 32'(lock_state), 3);
    window(0, 3, E_LEAD, 0);
    chk("t3_back_locked", 32'(lock_state), 2);
    chk("t3_err3", 32'(err_count), 3);
    window(0, 5, E_LAG, 0);
    chk("t3_hold_again", 32'(lock_state), 3);
    chk("t3_still_locked", 32'(locked), 1);
    window(0, 0, E_NONE, 0);
    chk("t3_locked_again", 32'(lock_state), 2);
    chk("t3_lock_pulses", 32'(lock_pulses), 2);
    chk("t3_unlock_pulses", 32'(unlock_pulses), 1);

    window(15, 1, E_LAG, 0);
    chk("t4_last_cycle", 32'(err_count), 1);
    window(0, 1, E_LEAD, 0);
    chk("t4_first_cycle", 32'(err_count), 1);
    chk("t4_state", 32'(lock_state), 2);

    window(0, 0, E_NONE, 1);
    chk("t5_wrap", 32'(wrap_count), 4);
    chk("t5_wrap_sat_dut", 32'(wrap_count2), 4);
    chk("t5_wrap_err", 32'(err_count), 0);
    window(0, WL, E_LAG, 0);
    chk("t5_err_full", 32'(err_count), 16);
    chk("t5_err_sat", 32'(err_count2), 15);
    chk("t5_wrap_zero", 32'(wrap_count), 0);
    chk("t5_hold", 32'(lock_state), 3);
    window(0, WL, E_LAG, 0);
    chk("t5_unlocked", 32'(lock_state), 0);
    chk("t5_unlock_pulses", 32'(unlock_pulses), 2);

    for (int w = 0; w < 3; w++) window(4, 1, E_LAG, 0);
    chk("t6_relock", 32'(lock_state), 2);
    chk("t6_lock_pulses", 32'(lock_pulses), 3);
    for (int i = 0; i < 5; i++) cyc(E_NONE, 8'h00);
    swiptAlive = 1'b0;
    cyc(E_ILL, 8'h00);
    chk("t6_drop_event", 32'(unlock_event), 1);
    chk("t6_drop_state", 32'(lock_state), 0);
    chk("t6_drop_locked", 32'(locked), 0);
    chk("t6_drop_err_held", 32'(err_count), 1);
    chk("t6_drop_no_illegal", 32'(illegal_seen), 0);
    chk("t6_unlock_pulses", 32'(unlock_pulses), 3);
    swiptAlive = 1'b1;
    window(3, 1, E_ILL, 0);
    chk("t6_illegal_set", 32'(illegal_seen), 1);
    chk("t6_illegal_err", 32'(err_count), 1);
    chk("t6_acq", 32'(lock_state), 1);
    window(0, 0, E_NONE, 0);
    chk("t6_illegal_sticky", 32'(illegal_seen), 1);
    for (int i = 0; i < 7; i++) cyc(i < 3 ? E_LAG : E_NONE, 8'h00);
    rst = 1'b1;
    cyc(E_NONE, 8'h00);
    chk("t6_rst_illegal", 32'(illegal_seen), 0);
    chk("t6_rst_state", 32'(lock_state), 0);
    chk("t6_rst_err", 32'(err_count), 0);
    rst = 1'b0;
    window(0, 1, E_LAG, 0);
    chk("t6_partial_discard", 32'(err_count), 1);
    chk("t6_post_rst_state", 32'(lock_state), 1);

    chk("end_lock_pulses", 32'(lock_pulses), 3);
    chk("end_unlock_pulses", 32'(unlock_pulses), 3);
    chk("end_never_both", 32'(both_pulses), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
